// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Sequences one Zicsr instruction (CSRRW/RS/RC and the immediate forms)
//   against the CSR register file. The old value is always read before the
//   clear/set/write is issued, so rd receives the pre-write value.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    op valid, sampled only in IDLE
//   funct3, csr_address      decoded op and target CSR
//   rs1_data, rs1_field      register operand / rs1 index or uimm
//   rd_field                 destination register index
//   busy, done, illegal      status; illegal and rd_write are valid with done
//   rd_write, rd_data        rd write enable and old CSR value (held until next done)
//   csr_read*                read request to the register file (data back one cycle later)
//   csr_write_back*          00 none, 01 clear, 10 set, 11 write
//
// state | meaning
// IDLE  | waiting for start
// READ  | read strobe to register file (if the op reads)
// CAPT  | read data arrives, captured into rd_data
// WRITE | write-back strobe (if the op writes)
// DONE  | done pulse, return to IDLE
module csr_access_unit #(
    parameter int XLEN       = 32,
    parameter int ENFORCE_RO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_address,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs1_field,
    input  logic [4:0]      rd_field,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic            rd_write,
    output logic [XLEN-1:0] rd_data,
    output logic            csr_read,
    output logic [11:0]     csr_read_address,
    input  logic [XLEN-1:0] csr_read_data,
    output logic [1:0]      csr_write_back,
    output logic [11:0]     csr_write_back_address,
    output logic [XLEN-1:0] csr_write_back_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] operand_q;
    logic [4:0]      rd_q;
    logic [1:0]      op_q;
    logic            do_read_q;
    logic            do_write_q;

    logic            dec_read;
    logic            dec_write;
    logic            dec_illegal;
    logic [1:0]      dec_op;
    logic [XLEN-1:0] dec_operand;

    // Write intent follows the rs1 field, not the operand value: CSRRS x0 with
    // rs1=x5 holding zero still counts as a write for the read-only check.
    assign dec_read    = !(funct3[1:0] == 2'b01 && rd_field == 5'd0);
    assign dec_write   = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
    assign dec_operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_data;
    assign dec_illegal = (funct3[1:0] == 2'b00)
                      || ((ENFORCE_RO != 0) && dec_write && csr_address[11:10] == 2'b11);

    always_comb begin
        dec_op = 2'b00;
        case (funct3[1:0])
            2'b01:   dec_op = 2'b11;
            2'b10:   dec_op = 2'b10;
            2'b11:   dec_op = 2'b01;
            default: dec_op = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            addr_q                 <= '0;
            operand_q              <= '0;
            rd_q                   <= '0;
            op_q                   <= '0;
            do_read_q              <= 1'b0;
            do_write_q             <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            illegal                <= 1'b0;
            rd_write               <= 1'b0;
            rd_data                <= '0;
            csr_read               <= 1'b0;
            csr_read_address       <= '0;
            csr_write_back         <= 2'b00;
            csr_write_back_address <= '0;
            csr_write_back_data    <= '0;
        end else begin
            // Strobes and their address/data are single-cycle pulses.
            done                   <= 1'b0;
            illegal                <= 1'b0;
            rd_write               <= 1'b0;
            csr_read               <= 1'b0;
            csr_read_address       <= '0;
            csr_write_back         <= 2'b00;
            csr_write_back_address <= '0;
            csr_write_back_data    <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= csr_address;
                        operand_q  <= dec_operand;
                        rd_q       <= rd_field;
                        op_q       <= dec_op;
                        do_read_q  <= dec_read;
                        do_write_q <= dec_write;
                        busy       <= 1'b1;
                        if (dec_illegal) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end else begin
                            state <= READ;
                            if (dec_read) begin
                                csr_read         <= 1'b1;
                                csr_read_address <= csr_address;
                            end
                        end
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    state <= WRITE;
                    if (do_read_q) begin
                        rd_data <= csr_read_data;
                    end
                    if (do_write_q) begin
                        csr_write_back         <= op_q;
                        csr_write_back_address <= addr_q;
                        csr_write_back_data    <= operand_q;
                    end
                end
                WRITE: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    rd_write <= do_read_q && (rd_q != 5'd0);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
